// File: rtl/deconv_result_streamer.sv
// Drains the transposed-convolution result memory in raster order, requantizing each word onto a valid/ready stream.
// Optional build macro STREAMER_ROUND_EN: round-to-nearest before the requantization shift.
module deconv_result_streamer #(
  parameter int N          = 2,
  parameter int K          = 3,
  parameter int pixel_bits = 8
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic                              i_start,
  input  logic [$clog2(pixel_bits*4)-1:0]   i_shift_amt,
  output logic [$clog2(N*K*N*K)-1:0]        o_rd_addr,
  input  logic [pixel_bits*4-1:0]           i_rd_data,
  output logic [pixel_bits-1:0]             o_out_data,
  output logic                              o_out_valid,
  input  logic                              i_out_ready,
  output logic                              o_out_last,
  output logic                              o_busy,
  output logic                              o_sweep_done
);

  localparam int ACC_W = pixel_bits * 4;
  localparam int TOTAL = N * K * N * K;
  localparam int AW    = $clog2(N * K * N * K);
  localparam int SW    = $clog2(pixel_bits * 4);
  localparam logic [AW-1:0] LAST_ADDR = AW'(TOTAL - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_SEND  = 2'd2
  } state_t;

  // Unsigned requantize: optional round, shift, then clamp to the pixel range.
  function automatic logic [pixel_bits-1:0] quant(
    input logic [ACC_W-1:0] x,
    input logic [SW-1:0]    sh
  );
    logic [ACC_W:0] sum;
    logic [ACC_W:0] s;
`ifdef STREAMER_ROUND_EN
    if (sh != {SW{1'b0}}) begin
      sum = {1'b0, x} + ({{ACC_W{1'b0}}, 1'b1} << (sh - {{(SW-1){1'b0}}, 1'b1}));
    end else begin
      sum = {1'b0, x};
    end
`else
    sum = {1'b0, x};
`endif
    s = sum >> sh;
    if (s > {{(ACC_W+1-pixel_bits){1'b0}}, {pixel_bits{1'b1}}}) begin
      quant = {pixel_bits{1'b1}};
    end else begin
      quant = s[pixel_bits-1:0];
    end
  endfunction

  state_t            r_state;
  state_t            w_next_state;
  logic [AW-1:0]     r_rd_addr;
  logic [pixel_bits-1:0] r_out_data;
  logic              r_out_valid;
  logic              r_out_last;
  logic              r_busy;
  logic              r_sweep_done;
  logic [SW-1:0]     r_shift;
  logic              w_start_ok;
  logic              w_accept;
  logic              w_at_last;

  // A start landing on the completion-pulse cycle is ignored; it is taken from the next idle cycle.
  assign w_start_ok = i_start && !r_sweep_done;
  assign w_accept   = r_out_valid && i_out_ready;
  assign w_at_last  = (r_rd_addr == LAST_ADDR);

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_start_ok) begin
          w_next_state = ST_FETCH;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_FETCH: begin
        w_next_state = ST_SEND;
      end
      ST_SEND: begin
        if (w_accept && w_at_last) begin
          w_next_state = ST_IDLE;
        end else if (w_accept) begin
          w_next_state = ST_FETCH;
        end else begin
          w_next_state = ST_SEND;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Datapath and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rd_addr    <= {AW{1'b0}};
      r_out_data   <= {pixel_bits{1'b0}};
      r_out_valid  <= 1'b0;
      r_out_last   <= 1'b0;
      r_busy       <= 1'b0;
      r_sweep_done <= 1'b0;
      r_shift      <= {SW{1'b0}};
    end else begin
      r_sweep_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_start_ok) begin
            r_shift   <= i_shift_amt;
            r_rd_addr <= {AW{1'b0}};
            r_busy    <= 1'b1;
          end
        end
        ST_FETCH: begin
          r_out_data  <= quant(i_rd_data, r_shift);
          r_out_valid <= 1'b1;
          r_out_last  <= w_at_last;
        end
        ST_SEND: begin
          if (w_accept) begin
            r_out_valid <= 1'b0;
            if (w_at_last) begin
              r_rd_addr    <= {AW{1'b0}};
              r_busy       <= 1'b0;
              r_sweep_done <= 1'b1;
            end else begin
              r_rd_addr <= r_rd_addr + {{(AW-1){1'b0}}, 1'b1};
            end
          end
        end
        default: begin
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign o_rd_addr    = r_rd_addr;
  assign o_out_data   = r_out_data;
  assign o_out_valid  = r_out_valid;
  assign o_out_last   = r_out_last;
  assign o_busy       = r_busy;
  assign o_sweep_done = r_sweep_done;

endmodule
